// File: rtl/m_imem_loader_if.sv
// m_imem_loader_if: word-memory write port driven by the serial loader.
// master = loader side, slave = memory side.
interface m_imem_loader_if #(
  parameter int ADDR_W = 12
);
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [31:0]       r_din;

  modport master (
    output r_addr,
    output r_we,
    output r_din
  );

  modport slave (
    input r_addr,
    input r_we,
    input r_din
  );
endinterface

// File: rtl/m_imem_loader.sv
// m_imem_loader: UART 8N1 program loader writing big-endian words from addr 0.
// Optional trailing XOR checksum byte: define IMEM_LOADER_CHECKSUM_EN.
module m_imem_loader #(
  parameter int BAUD_DIV = 434,
  parameter int ADDR_W   = 12
) (
  input  logic            w_clk,
  input  logic            w_rst_n,
  input  logic            w_rxd,
  m_imem_loader_if.master mem,
  output logic            r_proc_rst,
  output logic            r_done,
  output logic            r_err
);

  localparam logic [15:0] FULL_M1 = 16'(BAUD_DIV - 1);
  localparam logic [15:0] HALF_M1 = 16'(BAUD_DIV / 2 - 1);
  localparam logic [12:0] MAX_W   = 13'd4096;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_e;

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_CNT_HI,
    S_CNT_LO,
    S_DATA,
    S_CSUM,
    S_DONE
  } st_e;
`else
  typedef enum logic [2:0] {
    S_CNT_HI,
    S_CNT_LO,
    S_DATA,
    S_DONE
  } st_e;
`endif

  logic        sync1_q, sync2_q, prev_q;
  rx_e         rx_q, rx_d;
  logic [15:0] bcnt_q, bcnt_d;
  logic [2:0]  bidx_q, bidx_d;
  logic [7:0]  sh_q, sh_d;
  logic        stb_q, stb_d;
  logic        ferr_q, ferr_d;

  st_e               st_q, st_d;
  logic [7:0]        hi_q, hi_d;
  logic [12:0]       nw_q, nw_d;
  logic [12:0]       wc_q, wc_d;
  logic [1:0]        bsel_q, bsel_d;
  logic [23:0]       asm_q, asm_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [31:0]       din_q, din_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              prst_q, prst_d;
  logic [15:0]       cnt16;
  logic              last_wr;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
  logic              bad_q, bad_d;
`endif

  // two-flop synchronizer plus one delayed copy for falling-edge detect
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= w_rxd;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // UART receiver: mid-bit sampling, byte strobe or framing-error pulse
  always_comb begin
    rx_d   = rx_q;
    bcnt_d = bcnt_q;
    bidx_d = bidx_q;
    sh_d   = sh_q;
    stb_d  = 1'b0;
    ferr_d = 1'b0;
    unique case (rx_q)
      RX_IDLE: begin
        if (prev_q && !sync2_q) begin
          rx_d   = RX_START;
          bcnt_d = HALF_M1;
        end
      end
      RX_START: begin
        if (bcnt_q == '0) begin
          if (!sync2_q) begin
            rx_d   = RX_DATA;
            bcnt_d = FULL_M1;
            bidx_d = '0;
          end else begin
            rx_d = RX_IDLE;
          end
        end else begin
          bcnt_d = bcnt_q - 16'd1;
        end
      end
      RX_DATA: begin
        if (bcnt_q == '0) begin
          sh_d   = {sync2_q, sh_q[7:1]};
          bcnt_d = FULL_M1;
          bidx_d = bidx_q + 3'd1;
          if (bidx_q == 3'd7) rx_d = RX_STOP;
        end else begin
          bcnt_d = bcnt_q - 16'd1;
        end
      end
      RX_STOP: begin
        if (bcnt_q == '0) begin
          rx_d = RX_IDLE;
          if (sync2_q) stb_d = 1'b1;
          else         ferr_d = 1'b1;
        end else begin
          bcnt_d = bcnt_q - 16'd1;
        end
      end
      default: rx_d = RX_IDLE;
    endcase
  end

  // receiver state register
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      rx_q   <= RX_IDLE;
      bcnt_q <= '0;
      bidx_q <= '0;
      sh_q   <= '0;
      stb_q  <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      rx_q   <= rx_d;
      bcnt_q <= bcnt_d;
      bidx_q <= bidx_d;
      sh_q   <= sh_d;
      stb_q  <= stb_d;
      ferr_q <= ferr_d;
    end
  end

  assign cnt16   = {hi_q, sh_q};
  assign last_wr = we_q && ((wc_q + 13'd1) == nw_q);

  // loader FSM: count header, word assembly, write pulse, completion
  always_comb begin
    st_d   = st_q;
    hi_d   = hi_q;
    nw_d   = nw_q;
    bsel_d = bsel_q;
    asm_d  = asm_q;
    we_d   = 1'b0;
    din_d  = din_q;
    done_d = done_q;
    err_d  = err_q | ferr_q;
    addr_d = we_q ? addr_q + ADDR_W'(1) : addr_q;
    wc_d   = we_q ? wc_q + 13'd1 : wc_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d = csum_q;
    bad_d  = bad_q;
    prst_d = prst_q & ~(done_q & ~bad_q);
`else
    prst_d = prst_q & ~done_q;
`endif
    unique case (st_q)
      S_CNT_HI: begin
        if (stb_q) begin
          hi_d = sh_q;
          st_d = S_CNT_LO;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ sh_q;
`endif
        end
      end
      S_CNT_LO: begin
        if (stb_q) begin
          st_d = S_DATA;
          if (cnt16 == '0 || cnt16 > 16'd4096) nw_d = MAX_W;
          else                                 nw_d = cnt16[12:0];
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ sh_q;
`endif
        end
      end
      S_DATA: begin
        if (stb_q) begin
          asm_d  = {asm_q[15:0], sh_q};
          bsel_d = bsel_q + 2'd1;
          if (bsel_q == 2'd3) begin
            we_d  = 1'b1;
            din_d = {asm_q, sh_q};
          end
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ sh_q;
`endif
        end
        if (last_wr) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          st_d = S_CSUM;
`else
          st_d   = S_DONE;
          done_d = 1'b1;
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (stb_q) begin
          st_d   = S_DONE;
          done_d = 1'b1;
          if (sh_q != csum_q) begin
            err_d = 1'b1;
            bad_d = 1'b1;
          end
        end
      end
`endif
      S_DONE: done_d = 1'b1;
      default: st_d = S_CNT_HI;
    endcase
  end

  // loader state and output registers
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      st_q   <= S_CNT_HI;
      hi_q   <= '0;
      nw_q   <= '0;
      wc_q   <= '0;
      bsel_q <= '0;
      asm_q  <= '0;
      addr_q <= '0;
      we_q   <= 1'b0;
      din_q  <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      prst_q <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q <= '0;
      bad_q  <= 1'b0;
`endif
    end else begin
      st_q   <= st_d;
      hi_q   <= hi_d;
      nw_q   <= nw_d;
      wc_q   <= wc_d;
      bsel_q <= bsel_d;
      asm_q  <= asm_d;
      addr_q <= addr_d;
      we_q   <= we_d;
      din_q  <= din_d;
      done_q <= done_d;
      err_q  <= err_d;
      prst_q <= prst_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q <= csum_d;
      bad_q  <= bad_d;
`endif
    end
  end

  assign mem.r_addr = addr_q;
  assign mem.r_we   = we_q;
  assign mem.r_din  = din_q;
  assign r_proc_rst = prst_q;
  assign r_done     = done_q;
  assign r_err      = err_q;

endmodule
